// File: rtl/exec_cond_stage_if.sv
// EX-stage bundle: instruction/ALU inputs from upstream and EX/MEM register outputs.
// master drives the instruction side; slave is the condition/commit stage.
interface exec_cond_stage_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic [31:0]      alu_out;
  logic             alu_c, alu_z, alu_n, alu_v;
  logic [1:0]       alu_func;
  logic [3:0]       cond;
  logic             set_flags;
  logic [3:0]       rd_in;
  logic             wr_en_in;
  logic             stall;
  logic             flush;
  logic             cond_pass;
  logic [3:0]       flags_nzcv;
  logic             out_valid;
  logic [31:0]      out_result;
  logic [3:0]       out_rd;
  logic             out_wr_en;
  logic [CNT_W-1:0] exec_count;

  modport master (
    output in_valid, alu_out, alu_c, alu_z, alu_n, alu_v, alu_func, cond,
           set_flags, rd_in, wr_en_in, stall, flush,
    input  cond_pass, flags_nzcv, out_valid, out_result, out_rd, out_wr_en,
           exec_count
  );

  modport slave (
    input  in_valid, alu_out, alu_c, alu_z, alu_n, alu_v, alu_func, cond,
           set_flags, rd_in, wr_en_in, stall, flush,
    output cond_pass, flags_nzcv, out_valid, out_result, out_rd, out_wr_en,
           exec_count
  );
endinterface

// File: rtl/exec_cond_stage.sv
// Execute back end: NZCV flags, condition evaluation, gated writeback into the
// EX/MEM register (flush > stall > commit > bubble), saturating commit counter.
module exec_cond_stage #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  exec_cond_stage_if.slave ex
);

  logic [3:0]       flags_q, flags_d;
  logic             vld_q, vld_d;
  logic [31:0]      res_q, res_d;
  logic [3:0]       rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fn, fz, fc, fv;
  logic cond_pass;
  logic commit;

  assign {fn, fz, fc, fv} = flags_q;

  // Condition reads only the architectural flags, never the in-flight ALU flags.
  always_comb begin
    cond_pass = 1'b0;
    unique case (ex.cond)
      4'h0: cond_pass = fz;
      4'h1: cond_pass = ~fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = ~fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = ~fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = ~fv;
      4'h8: cond_pass = fc & ~fz;
      4'h9: cond_pass = ~fc | fz;
      4'hA: cond_pass = (fn == fv);
      4'hB: cond_pass = (fn != fv);
      4'hC: cond_pass = ~fz & (fn == fv);
      4'hD: cond_pass = fz | (fn != fv);
      4'hE: cond_pass = 1'b1;
      4'hF: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  assign commit = ex.in_valid & cond_pass & ~ex.stall & ~ex.flush;

  always_comb begin
    flags_d = flags_q;
    vld_d   = vld_q;
    res_d   = res_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;

    // Logical ops keep the old C/V; the ALU's forced-zero C/V is discarded.
    if (commit && ex.set_flags) begin
      flags_d[3] = ex.alu_n;
      flags_d[2] = ex.alu_z;
      if (!ex.alu_func[1]) begin
        flags_d[1] = ex.alu_c;
        flags_d[0] = ex.alu_v;
      end
    end

    if (ex.flush) begin
      vld_d = 1'b0;
      wr_d  = 1'b0;
    end else if (ex.stall) begin
      vld_d = vld_q;
    end else if (commit) begin
      vld_d = 1'b1;
      res_d = ex.alu_out;
      rd_d  = ex.rd_in;
      wr_d  = ex.wr_en_in;
    end else begin
      vld_d = 1'b0;
      wr_d  = 1'b0;
    end

    if (commit && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
      vld_q   <= 1'b0;
      res_q   <= 32'h0;
      rd_q    <= 4'h0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex.cond_pass  = cond_pass;
  assign ex.flags_nzcv = flags_q;
  assign ex.out_valid  = vld_q;
  assign ex.out_result = res_q;
  assign ex.out_rd     = rd_q;
  assign ex.out_wr_en  = wr_q;
  assign ex.exec_count = cnt_q;

endmodule

// File: tb/tb_exec_cond_stage.sv
// Directed bench for exec_cond_stage with a 4-bit counter so saturation is reachable.
module tb_exec_cond_stage;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  exec_cond_stage_if #(.CNT_W(CNT_W)) ex ();

  exec_cond_stage #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (ex)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [31:0] res, input logic [3:0] nzcv, input logic [1:0] fn,
                       input logic [3:0] cc, input logic sf, input logic [3:0] rd, input logic we);
    ex.in_valid  = 1'b1;
    ex.alu_out   = res;
    {ex.alu_n, ex.alu_z, ex.alu_c, ex.alu_v} = nzcv;
    ex.alu_func  = fn;
    ex.cond      = cc;
    ex.set_flags = sf;
    ex.rd_in     = rd;
    ex.wr_en_in  = we;
  endtask

  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= 15) ? 15 : c + 1;
  endfunction

  initial begin
    rst_n = 1'b0;
    ex.in_valid = 1'b0; ex.alu_out = '0; ex.alu_c = 0; ex.alu_z = 0; ex.alu_n = 0; ex.alu_v = 0;
    ex.alu_func = 2'b00; ex.cond = 4'hE; ex.set_flags = 0; ex.rd_in = 0; ex.wr_en_in = 0;
    ex.stall = 0; ex.flush = 0;
    step();
    chk("rst_flags", 32'(ex.flags_nzcv), 32'h0);
    chk("rst_valid", 32'(ex.out_valid), 32'h0);
    chk("rst_result", ex.out_result, 32'h0);
    chk("rst_rd", 32'(ex.out_rd), 32'h0);
    chk("rst_wren", 32'(ex.out_wr_en), 32'h0);
    chk("rst_cnt", 32'(ex.exec_count), 32'h0);
    rst_n = 1'b1;
    step();

    // SUB 5-5, AL, sets flags Z,C
    instr(32'h0, 4'b0110, 2'b01, 4'hE, 1'b1, 4'd3, 1'b1);
    #1 chk("sub_condpass", 32'(ex.cond_pass), 32'h1);
    step(); exp_cnt = 1;
    chk("sub_flags", 32'(ex.flags_nzcv), 32'h6);
    chk("sub_valid", 32'(ex.out_valid), 32'h1);
    chk("sub_result", ex.out_result, 32'h0);
    chk("sub_rd", 32'(ex.out_rd), 32'h3);
    chk("sub_wren", 32'(ex.out_wr_en), 32'h1);
    chk("sub_cnt", 32'(ex.exec_count), 32'(exp_cnt));

    // NE with Z=1 fails: bubble, no flag change
    instr(32'h1234, 4'b1001, 2'b00, 4'h1, 1'b1, 4'd5, 1'b1);
    #1 chk("ne_condpass", 32'(ex.cond_pass), 32'h0);
    step();
    chk("ne_valid", 32'(ex.out_valid), 32'h0);
    chk("ne_wren", 32'(ex.out_wr_en), 32'h0);
    chk("ne_flags", 32'(ex.flags_nzcv), 32'h6);
    chk("ne_result_hold", ex.out_result, 32'h0);
    chk("ne_cnt", 32'(ex.exec_count), 32'(exp_cnt));

    // EQ passes
    instr(32'h1234, 4'b1001, 2'b00, 4'h0, 1'b0, 4'd5, 1'b1);
    #1 chk("eq_condpass", 32'(ex.cond_pass), 32'h1);
    step(); exp_cnt = 2;
    chk("eq_valid", 32'(ex.out_valid), 32'h1);
    chk("eq_result", ex.out_result, 32'h1234);
    chk("eq_rd", 32'(ex.out_rd), 32'h5);
    chk("eq_flags", 32'(ex.flags_nzcv), 32'h6);
    chk("eq_cnt", 32'(ex.exec_count), 32'(exp_cnt));

    // Arithmetic sets flags to 0011, then AND keeps C/V
    instr(32'h7, 4'b0011, 2'b01, 4'hE, 1'b1, 4'd1, 1'b1);
    step(); exp_cnt = 3;
    chk("arith_flags", 32'(ex.flags_nzcv), 32'h3);
    instr(32'h8000_0000, 4'b1000, 2'b10, 4'hE, 1'b1, 4'd2, 1'b1);
    step(); exp_cnt = 4;
    chk("and_flags", 32'(ex.flags_nzcv), 32'hB);
    chk("and_result", ex.out_result, 32'h8000_0000);

    // Signed compares with N=1,V=1,Z=0
    ex.in_valid = 1'b0;
    ex.cond = 4'hA; #1 chk("ge_nv11", 32'(ex.cond_pass), 32'h1);
    ex.cond = 4'hB; #1 chk("lt_nv11", 32'(ex.cond_pass), 32'h0);
    ex.cond = 4'hC; #1 chk("gt_nv11", 32'(ex.cond_pass), 32'h1);
    step();
    instr(32'h9, 4'b1000, 2'b00, 4'hE, 1'b1, 4'd4, 1'b1);
    step(); exp_cnt = 5;
    chk("add_flags_1000", 32'(ex.flags_nzcv), 32'h8);
    ex.in_valid = 1'b0;
    ex.cond = 4'hD; #1 chk("le_n1v0", 32'(ex.cond_pass), 32'h1);
    ex.cond = 4'hC; #1 chk("gt_n1v0", 32'(ex.cond_pass), 32'h0);

    // Full sweep: every flag value against every condition code
    for (int f = 0; f < 16; f++) begin
      instr(32'(f), 4'(f), 2'b00, 4'hE, 1'b1, 4'd6, 1'b1);
      step(); exp_cnt = sat_inc(exp_cnt);
      chk("sweep_flags", 32'(ex.flags_nzcv), 32'(f));
      chk("sweep_cnt", 32'(ex.exec_count), 32'(exp_cnt));
      ex.in_valid = 1'b0;
      for (int c = 0; c < 16; c++) begin
        ex.cond = 4'(c);
        #1 chk($sformatf("sweep_c%0h_f%0h", c, f), 32'(ex.cond_pass), 32'(cond_ref(4'(c), 4'(f))));
      end
    end

    // Async reset between edges, with a valid instruction waiting
    instr(32'h55, 4'b0000, 2'b00, 4'hE, 1'b1, 4'd2, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_flags", 32'(ex.flags_nzcv), 32'h0);
    chk("arst_valid", 32'(ex.out_valid), 32'h0);
    chk("arst_result", ex.out_result, 32'h0);
    chk("arst_rd", 32'(ex.out_rd), 32'h0);
    chk("arst_wren", 32'(ex.out_wr_en), 32'h0);
    chk("arst_cnt", 32'(ex.exec_count), 32'h0);
    step(); #2;
    rst_n = 1'b1;
    #1;
    chk("release_valid", 32'(ex.out_valid), 32'h0);
    chk("release_cnt", 32'(ex.exec_count), 32'h0);
    step(); exp_cnt = 1;
    chk("post_rst_valid", 32'(ex.out_valid), 32'h1);
    chk("post_rst_result", ex.out_result, 32'h55);
    chk("post_rst_cnt", 32'(ex.exec_count), 32'(exp_cnt));

    // Stall holds everything for 3 cycles, then commits
    instr(32'hDEAD, 4'b1010, 2'b00, 4'hE, 1'b1, 4'd9, 1'b0);
    ex.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 32'(ex.out_valid), 32'h1);
      chk("stall_result", ex.out_result, 32'h55);
      chk("stall_rd", 32'(ex.out_rd), 32'h2);
      chk("stall_flags", 32'(ex.flags_nzcv), 32'h0);
      chk("stall_cnt", 32'(ex.exec_count), 32'(exp_cnt));
    end
    ex.stall = 1'b0;
    step(); exp_cnt = 2;
    chk("unstall_result", ex.out_result, 32'hDEAD);
    chk("unstall_rd", 32'(ex.out_rd), 32'h9);
    chk("unstall_wren", 32'(ex.out_wr_en), 32'h0);
    chk("unstall_flags", 32'(ex.flags_nzcv), 32'hA);
    chk("unstall_cnt", 32'(ex.exec_count), 32'(exp_cnt));

    // Flush beats stall
    instr(32'hBEEF, 4'b0100, 2'b00, 4'hE, 1'b1, 4'd7, 1'b1);
    ex.stall = 1'b1; ex.flush = 1'b1;
    #1 chk("flush_condpass", 32'(ex.cond_pass), 32'h1);
    step();
    chk("flush_valid", 32'(ex.out_valid), 32'h0);
    chk("flush_wren", 32'(ex.out_wr_en), 32'h0);
    chk("flush_result", ex.out_result, 32'hDEAD);
    chk("flush_rd", 32'(ex.out_rd), 32'h9);
    chk("flush_flags", 32'(ex.flags_nzcv), 32'hA);
    chk("flush_cnt", 32'(ex.exec_count), 32'(exp_cnt));
    ex.stall = 1'b0; ex.flush = 1'b0;

    // 20 commits saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      instr(32'(i), 4'b0000, 2'b00, 4'hE, 1'b0, 4'd1, 1'b1);
      step(); exp_cnt = sat_inc(exp_cnt);
      chk($sformatf("sat_cnt_%0d", i), 32'(ex.exec_count), 32'(exp_cnt));
    end
    chk("sat_final", 32'(ex.exec_count), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/exec_cond_stage.md
# exec_cond_stage

Execute-stage back end that sits directly downstream of the 32-bit ALU (ADD/SUB/AND/OR, combinational C/Z/N/V). It holds the architectural NZCV flags register and evaluates the instruction's 4-bit condition code against it. It gates writeback and flag updates on that condition, then registers the ALU result into the EX/MEM pipeline register with stall and flush control. A saturating counter records committed instructions.

## Interface
Parameters:
- CNT_W, 16, width of committed-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  an instruction occupies EX this cycle
- alu_out  in  32  ALU result
- alu_c, alu_z, alu_n, alu_v  in  1 each  ALU flags for this instruction
- alu_func  in  2  ALU function (00 ADD, 01 SUB, 10 AND, 11 OR)
- cond  in  4  condition code
- set_flags  in  1  instruction writes NZCV
- rd_in  in  4  destination register index
- wr_en_in  in  1  instruction writes rd
- stall  in  1  downstream not ready; hold pipeline register
- flush  in  1  kill the instruction in EX
- cond_pass  out  1  combinational condition result for the current EX instruction
- flags_nzcv  out  4  architectural flags {N,Z,C,V}
- out_valid  out  1  EX/MEM register holds a committed instruction
- out_result  out  32  registered result
- out_rd  out  4  registered destination index
- out_wr_en  out  1  registered write enable
- exec_count  out  CNT_W  committed-instruction count, saturating

## Operation
- cond_pass is evaluated against flags_nzcv only, never against the alu_* inputs. Encoding:
  - 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V
  - 8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 0
- commit = in_valid & cond_pass & ~stall & ~flush.
- Flag update occurs on commit & set_flags:
  - N and Z always load from alu_n and alu_z.
  - When alu_func[1]=0 (arithmetic), C and V load from alu_c and alu_v.
  - When alu_func[1]=1 (logical), C and V keep their old values. The ALU's forced-zero C/V is ignored.
- Pipeline register, evaluated in priority order each edge:
  - flush=1: out_valid←0, out_wr_en←0. out_result and out_rd keep their values. Flags unchanged. flush wins over stall.
  - else stall=1: all output registers and flags hold.
  - else commit: out_valid←1, out_result←alu_out, out_rd←rd_in, out_wr_en←wr_en_in.
  - else (bubble or condition failed): out_valid←0, out_wr_en←0. out_result and out_rd keep their values.
- exec_count increments by 1 on each commit and saturates at all-ones.
- Reset (rst_n=0, asynchronous): flags_nzcv=0000, out_valid=0, out_result=0, out_rd=0, out_wr_en=0, exec_count=0. Deasserting reset mid-stream causes no spurious commit; the first edge after release follows the normal rules.

## Timing
- One-cycle latency. An instruction present in EX at edge k appears on out_* after edge k.
- Flags written by the instruction committing at edge k are visible to cond_pass from edge k onward. Back-to-back dependent instructions therefore need no bypass.
- cond_pass is purely combinational from flags_nzcv and cond. It does not depend on stall or flush.
- While stall is asserted, the upstream stage holds its instruction steady in EX. The instruction commits on the first edge where stall=0.
- flush and reset take effect on the current edge or immediately, respectively. A flushed instruction never updates flags or exec_count.

## Test plan
- Reset then flag-setting SUB: flags=0000. Present SUB 5-5 with cond=E, set_flags=1, alu_z=1, alu_c=1 -> after edge, flags_nzcv=0110, out_valid=1, out_result=0, exec_count=1.
- Condition gating: with flags Z=1, issue ADD with cond=1 (NE) -> cond_pass=0, out_valid=0, out_wr_en=0, flags unchanged. Next, cond=0 (EQ) -> cond_pass=1, commit.
- Logical op preserves C/V: flags=0011. AND with set_flags=1 producing 0x80000000 (alu_n=1, alu_c=0, alu_v=0) -> flags_nzcv=1011.
- Signed compares: flags N=1, V=1 -> GE=1, LT=0, GT=1. Flags N=1, V=0, Z=0 -> LE=1, GT=0. Full sweep of all 16 cond codes over all 16 flag values, checked against the encoding table.
- Stall then flush: hold a valid AL instruction with stall=1 for 3 cycles -> outputs and flags frozen, exec_count unchanged. Assert stall=1 and flush=1 together -> out_valid=0, flags unchanged.
- Counter saturation and async reset: with CNT_W=4, commit 20 instructions -> exec_count=15. Drop rst_n between clock edges -> all outputs 0 immediately.
